// File: rtl/cnn_pkg.sv
// Shared CNN constants and types used by the classification stage.
package cnn_pkg;

  localparam int unsigned NUM_CLASS_C = 10;
  localparam int unsigned SCORE_W_C   = 32;
  localparam int unsigned IDX_W_C     = 4;

  typedef logic signed [31:0] score_t;
  typedef logic [3:0]         class_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational compare/update cell for the argmax scan.
// Strict signed greater-than, so ties keep the incumbent (lower) index.
// With ARGMAX_MARGIN_EN defined, the runner-up score is also updated.
module argmax_cmp #(
  parameter int unsigned SCORE_W = 32,
  parameter int unsigned IDX_W   = 4
) (
  input  logic signed [SCORE_W-1:0] best,
  input  logic        [IDX_W-1:0]   best_idx,
  input  logic signed [SCORE_W-1:0] cand,
  input  logic        [IDX_W-1:0]   cand_idx,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [SCORE_W-1:0] second,
  output logic signed [SCORE_W-1:0] new_second,
`endif
  output logic signed [SCORE_W-1:0] new_best,
  output logic        [IDX_W-1:0]   new_best_idx
);

  logic win;
  assign win = cand > best;

  // Replace the incumbent only on a strictly larger candidate.
  always_comb begin
    new_best     = best;
    new_best_idx = best_idx;
    if (win) begin
      new_best     = cand;
      new_best_idx = cand_idx;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  // A displaced best becomes the runner-up; otherwise a larger loser replaces it.
  always_comb begin
    new_second = second;
    if (win) begin
      new_second = best;
    end else if (cand > second) begin
      new_second = cand;
    end
  end
`endif

endmodule

// File: rtl/argmax_unit.sv
// Final classification stage: captures the class scores on start, scans them
// one per clock and presents the winning index with a valid/ack handshake.
// Optional macro ARGMAX_MARGIN_EN adds runner-up, margin and low-confidence outputs.
module argmax_unit
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_CLASS  = NUM_CLASS_C,
  parameter int unsigned SCORE_W    = SCORE_W_C,
  parameter int unsigned IDX_W      = IDX_W_C
`ifdef ARGMAX_MARGIN_EN
  ,
  parameter int unsigned MARGIN_THR = 0
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CLASS*SCORE_W-1:0] scores,
  output logic                         busy,
  output logic                         result_valid,
  output logic [IDX_W-1:0]             result,
  output logic [SCORE_W-1:0]           max_score,
`ifdef ARGMAX_MARGIN_EN
  output logic [SCORE_W-1:0]           second_score,
  output logic [SCORE_W:0]             margin,
  output logic                         low_conf,
`endif
  input  logic                         result_ack
);

  localparam logic [IDX_W-1:0]   LastIdx  = IDX_W'(NUM_CLASS - 1);
  localparam logic [SCORE_W-1:0] MinScore = {1'b1, {(SCORE_W-1){1'b0}}};

  argmax_state_e state_q, state_d;

  logic signed [SCORE_W-1:0] bank_q [NUM_CLASS];
  logic        [IDX_W-1:0]   idx_q;
  logic signed [SCORE_W-1:0] best_q;
  logic        [IDX_W-1:0]   best_idx_q;
  logic signed [SCORE_W-1:0] upd_best;
  logic        [IDX_W-1:0]   upd_idx;
  logic                      capture;
`ifdef ARGMAX_MARGIN_EN
  logic signed [SCORE_W-1:0] second_q;
  logic signed [SCORE_W-1:0] upd_second;
`endif

  argmax_cmp #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_cmp (
    .best         (best_q),
    .best_idx     (best_idx_q),
    .cand         (bank_q[idx_q]),
    .cand_idx     (idx_q),
`ifdef ARGMAX_MARGIN_EN
    .second       (second_q),
    .new_second   (upd_second),
`endif
    .new_best     (upd_best),
    .new_best_idx (upd_idx)
  );

  // Next state; start in DONE only counts when it coincides with the ack.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == LastIdx) state_d = DONE;
      end
      DONE: begin
        if (result_ack) begin
          capture = start;
          state_d = start ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, score bank and scan registers; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_q   <= '0;
`endif
      for (int unsigned i = 0; i < NUM_CLASS; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        for (int unsigned i = 0; i < NUM_CLASS; i++) begin
          bank_q[i] <= scores[i*SCORE_W +: SCORE_W];
        end
        best_q     <= scores[0 +: SCORE_W];
        best_idx_q <= '0;
        idx_q      <= IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
        // Start the runner-up at the most negative value so any loser can claim it.
        second_q   <= MinScore;
`endif
      end else if (state_q == SCAN) begin
        best_q     <= upd_best;
        best_idx_q <= upd_idx;
`ifdef ARGMAX_MARGIN_EN
        second_q   <= upd_second;
`endif
        if (idx_q != LastIdx) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign busy         = (state_q == SCAN);
  assign result_valid = (state_q == DONE);
  assign result       = best_idx_q;
  assign max_score    = best_q;

`ifdef ARGMAX_MARGIN_EN
  logic [SCORE_W:0] margin_raw;

  // Best never falls below the runner-up, so the widened difference is non-negative.
  always_comb begin
    margin_raw = {best_q[SCORE_W-1], best_q} - {second_q[SCORE_W-1], second_q};
  end

  assign second_score = result_valid ? second_q : '0;
  assign margin       = result_valid ? margin_raw : '0;
  assign low_conf     = result_valid && (margin_raw <= (SCORE_W+1)'(MARGIN_THR));
`endif

endmodule

// File: tb/tb_argmax_unit.sv
// Scoreboard bench for argmax_unit: stimulus pushes hand-computed expectations,
// a monitor pops and compares them on each rising result_valid.
module tb_argmax_unit;

  localparam int NC = 10;
  localparam int SW = 32;

  typedef int vec_t [NC];
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] max;
    int          start_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [NC*SW-1:0] scores = '0;
  logic             busy;
  logic             result_valid;
  logic [3:0]       result;
  logic [SW-1:0]    max_score;
  logic             result_ack = 1'b0;
`ifdef ARGMAX_MARGIN_EN
  logic [SW-1:0]    second_score;
  logic [SW:0]      margin;
  logic             low_conf;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  argmax_unit #(
`ifdef ARGMAX_MARGIN_EN
    .MARGIN_THR   (2),
`endif
    .NUM_CLASS    (NC),
    .SCORE_W      (SW),
    .IDX_W        (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .scores       (scores),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .max_score    (max_score),
`ifdef ARGMAX_MARGIN_EN
    .second_score (second_score),
    .margin       (margin),
    .low_conf     (low_conf),
`endif
    .result_ack   (result_ack)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_scores(input vec_t v);
    for (int i = 0; i < NC; i++) scores[i*SW +: SW] = v[i];
  endtask

  // Issue a start pulse at the next negedge and log its expected result.
  task automatic issue(input vec_t v, input logic [3:0] eidx, input logic [31:0] emax,
                       input logic ack);
    exp_t e;
    @(negedge clk);
    set_scores(v);
    start      = 1'b1;
    result_ack = ack;
    e.idx       = eidx;
    e.max       = emax;
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    result_ack = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      if (result_valid) break;
      @(negedge clk);
    end
    if (!result_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid: got 0 expected 1 within 40 cycles");
    end
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("valid_drop_after_ack", 64'(result_valid), 64'd0);
  endtask

  // Monitor: compare each new result against the oldest expectation.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (result_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(result_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e.idx));
          check("max_score", {32'd0, max_score}, {32'd0, e.max});
          check("latency", 64'(cyc - e.start_cyc), 64'd9);
          check("busy_in_done", 64'(busy), 64'd0);
        end
      end
      prev_v = result_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v1, v2, v3, vb, vc, vr, vm;
    int   bcnt;
    v1 = '{3, -1, 7, 2, 0, 7, -5, 1, 4, 6};
    v2 = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -100};
    for (int i = 0; i < NC; i++) v3[i] = int'(32'h8000_0000);
    v3[9] = int'(32'h7FFF_FFFF);
    vb = '{0, 0, 0, 0, 0, 100, 0, 0, 0, 0};
    vc = '{-5, -3, -8, -3, -1, -2, -9, -1, -7, -4};
    vr = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -1};
    vm = '{1, 5, 4, 0, 0, 0, 0, 0, 0, 0};

    // Reset state.
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_max", {32'd0, max_score}, 64'd0);
    rst = 1'b1;

    // Tie between classes 2 and 5 resolves to 2; busy spans the 9 scan cycles.
    issue(v1, 4'd2, 32'd7, 1'b0);
    bcnt = 1;
    for (int i = 0; i < 20; i++) begin
      if (result_valid) break;
      @(negedge clk);
      if (busy) bcnt++;
    end
    check("busy_cycles", 64'(bcnt), 64'd9);
    wait_valid();
    ack_result();

    // All equal negative scores.
    issue(v2, 4'd0, 32'hFFFF_FF9C, 1'b0);
    wait_valid();
    ack_result();

    // Extremes: max positive at the last index.
    issue(v3, 4'd9, 32'h7FFF_FFFF, 1'b0);
    wait_valid();
    ack_result();

    // Start during SCAN is ignored and later bus changes have no effect.
    issue(v1, 4'd2, 32'd7, 1'b0);
    @(negedge clk);
    set_scores(vb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_scores(vc);
    wait_valid();
    // Hold without ack: result stays put, and a bare start is ignored.
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge clk);
      check("hold_valid", 64'(result_valid), 64'd1);
      check("hold_result", 64'(result), 64'd2);
      check("hold_max", {32'd0, max_score}, 64'd7);
    end
    start = 1'b0;
    // Start with ack together: retire and rescan directly.
    issue(vc, 4'd4, 32'hFFFF_FFFF, 1'b1);
    check("valid_drop_on_restart", 64'(result_valid), 64'd0);
    check("busy_on_restart", 64'(busy), 64'd1);
    wait_valid();
    ack_result();

    // Reset at the 4th SCAN cycle aborts with no partial result.
    issue(v1, 4'd2, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(result_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_max", {32'd0, max_score}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(vr, 4'd8, 32'd90, 1'b0);
    wait_valid();
    ack_result();

    // Runner-up tracking case.
    issue(vm, 4'd1, 32'd5, 1'b0);
    wait_valid();
`ifdef ARGMAX_MARGIN_EN
    check("second_score", {32'd0, second_score}, 64'd4);
    check("margin", 64'(margin), 64'd1);
    check("low_conf", 64'(low_conf), 64'd1);
`endif
    ack_result();

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
